// File: rtl/dal_pkg.sv
// Shared definitions for the DAL compute pipeline: lane defaults, the per-beat
// mode encoding, and the 32->16 signed saturation helper.
package dal_pkg;

    localparam int LANES_DEF = 4;
    localparam int W_DEF     = 16;

    typedef enum logic {
        MODE_SCALE   = 1'b0,
        MODE_NORMPOS = 1'b1
    } mode_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] value);
        logic signed [15:0] result;
        if (value > 32'sd32767) begin
            result = 16'sh7fff;
        end else if (value < -32'sd32768) begin
            result = 16'sh8000;
        end else begin
            result = value[15:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/dal_scale_lane.sv
// One lane of the Q8.8 scale path: signed multiply, round half toward +inf,
// then saturate back to 16 bits. Purely combinational.
module dal_scale_lane
    import dal_pkg::*;
(
    input  logic [W_DEF-1:0] operand,
    input  logic [W_DEF-1:0] scale,
    output logic [W_DEF-1:0] result
);

    logic signed [31:0] prod_s;
    logic signed [31:0] rnd_s;

    // Sign-extended operands keep the low 32 product bits exact for two's complement.
    always_comb begin
        prod_s = {{16{operand[15]}}, operand} * {{16{scale[15]}}, scale};
        rnd_s  = prod_s + 32'sd128;
        result = sat16(rnd_s >>> 8);
    end

endmodule

// File: rtl/dal_pipe_stage2.sv
// DAL pipeline stage 2: builds the two tile operand vectors per beat (scale or
// position-based routing) and tracks position/segment for later stages.
module dal_pipe_stage2
    import dal_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int W       = W_DEF,
    parameter int POS_W   = 16,
    parameter int STAGE_W = 4
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    input  logic                 stall_i,
    input  logic                 stage_boundary,
    input  logic [LANES*W-1:0]   operand_i,
    input  logic [W-1:0]         scale_i,
    input  logic                 mode,
    output logic [LANES*W-1:0]   operand1_o,
    output logic [LANES*W-1:0]   operand2_o,
    output logic [POS_W-1:0]     pos,
    output logic                 finished,
    output logic [STAGE_W-1:0]   stage
);

    localparam int CMP_W = (POS_W > W) ? POS_W : W;

    logic [LANES*W-1:0] scaled_s;
    logic [LANES*W-1:0] op1_nxt_s;
    logic [LANES*W-1:0] op2_nxt_s;
    logic [POS_W-1:0]   pos_cnt_nxt_s;
    logic [STAGE_W-1:0] seg_cnt_nxt_s;
    logic               below_thr_s;

    logic [POS_W-1:0]   pos_cnt_r;
    logic [STAGE_W-1:0] seg_cnt_r;
    logic [LANES*W-1:0] op1_r;
    logic [LANES*W-1:0] op2_r;
    logic [POS_W-1:0]   pos_r;
    logic               finished_r;
    logic [STAGE_W-1:0] stage_r;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dal_scale_lane u_lane (
            .operand (operand_i[k*W +: W]),
            .scale   (scale_i),
            .result  (scaled_s[k*W +: W])
        );
    end

    // Operand selection for the beat being accepted.
    always_comb begin
        op1_nxt_s   = '0;
        op2_nxt_s   = '0;
        below_thr_s = (CMP_W'(pos_cnt_r) < CMP_W'(scale_i));
        case (mode_e'(mode))
            MODE_SCALE: begin
                op1_nxt_s = scaled_s;
                op2_nxt_s = operand_i;
            end
            MODE_NORMPOS: begin
                if (below_thr_s) begin
                    op1_nxt_s = operand_i;
                end else begin
                    op2_nxt_s = operand_i;
                end
            end
            default: begin
                op1_nxt_s = '0;
                op2_nxt_s = '0;
            end
        endcase
    end

    // Position/segment advance; position saturates so very long segments stay pinned at all-ones.
    always_comb begin
        pos_cnt_nxt_s = pos_cnt_r;
        seg_cnt_nxt_s = seg_cnt_r;
        if (stage_boundary) begin
            pos_cnt_nxt_s = '0;
            seg_cnt_nxt_s = seg_cnt_r + STAGE_W'(1);
        end else if (pos_cnt_r != {POS_W{1'b1}}) begin
            pos_cnt_nxt_s = pos_cnt_r + POS_W'(1);
        end else begin
            pos_cnt_nxt_s = pos_cnt_r;
        end
    end

    // Counters and output registers; everything holds while stalled.
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            pos_cnt_r  <= '0;
            seg_cnt_r  <= '0;
            op1_r      <= '0;
            op2_r      <= '0;
            pos_r      <= '0;
            finished_r <= 1'b0;
            stage_r    <= '0;
        end else if (!stall_i) begin
            pos_cnt_r  <= pos_cnt_nxt_s;
            seg_cnt_r  <= seg_cnt_nxt_s;
            op1_r      <= op1_nxt_s;
            op2_r      <= op2_nxt_s;
            pos_r      <= pos_cnt_r;
            finished_r <= stage_boundary;
            stage_r    <= seg_cnt_r;
        end
    end

    assign operand1_o = op1_r;
    assign operand2_o = op2_r;
    assign pos        = pos_r;
    assign finished   = finished_r;
    assign stage      = stage_r;

endmodule

// File: tb/tb_dal_pipe_stage2.sv
// Self-checking bench for dal_pipe_stage2: a behavioural model compared every
// cycle, plus hand-computed literal expectations on directed beats.
module tb_dal_pipe_stage2;

    localparam int LANES   = 4;
    localparam int W       = 16;
    localparam int POS_W   = 16;
    localparam int STAGE_W = 4;

    logic               CLK_i = 1'b0;
    logic               RST_i;
    logic               stall_i;
    logic               stage_boundary;
    logic [63:0]        operand_i;
    logic [15:0]        scale_i;
    logic               mode;
    logic [63:0]        operand1_o;
    logic [63:0]        operand2_o;
    logic [15:0]        pos;
    logic               finished;
    logic [3:0]         stage;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    dal_pipe_stage2 #(
        .LANES   (LANES),
        .W       (W),
        .POS_W   (POS_W),
        .STAGE_W (STAGE_W)
    ) dut (
        .CLK_i          (CLK_i),
        .RST_i          (RST_i),
        .stall_i        (stall_i),
        .stage_boundary (stage_boundary),
        .operand_i      (operand_i),
        .scale_i        (scale_i),
        .mode           (mode),
        .operand1_o     (operand1_o),
        .operand2_o     (operand2_o),
        .pos            (pos),
        .finished       (finished),
        .stage          (stage)
    );

    always #5 CLK_i = ~CLK_i;

    // ---------------- behavioural model ----------------
    logic [63:0] m_op1, m_op2;
    int          m_pos_out, m_stage_out;
    bit          m_fin;
    int          m_pos, m_seg;

    function automatic logic [63:0] scale_vec(input logic [63:0] v, input logic [15:0] s);
        logic [63:0] r;
        longint p, q;
        for (int k = 0; k < 4; k++) begin
            p = longint'($signed(v[k*16 +: 16])) * longint'($signed(s));
            q = (p + 128) >>> 8;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            r[k*16 +: 16] = q[15:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    always @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            m_op1 <= 64'd0; m_op2 <= 64'd0;
            m_pos_out <= 0; m_stage_out <= 0; m_fin <= 1'b0;
            m_pos <= 0; m_seg <= 0;
        end else if (!stall_i) begin
            if (mode == 1'b0) begin
                m_op1 <= scale_vec(operand_i, scale_i);
                m_op2 <= operand_i;
            end else if (m_pos < int'(scale_i)) begin
                m_op1 <= operand_i;
                m_op2 <= 64'd0;
            end else begin
                m_op1 <= 64'd0;
                m_op2 <= operand_i;
            end
            m_pos_out   <= m_pos;
            m_stage_out <= m_seg;
            m_fin       <= stage_boundary;
            if (stage_boundary) begin
                m_pos <= 0;
                m_seg <= (m_seg + 1) % 16;
            end else begin
                m_pos <= (m_pos == 65535) ? 65535 : m_pos + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge CLK_i) begin
        if (chk_en) begin
            chk("model_op1",   operand1_o,       m_op1);
            chk("model_op2",   operand2_o,       m_op2);
            chk("model_pos",   64'(pos),         64'(m_pos_out));
            chk("model_stage", 64'(stage),       64'(m_stage_out));
            chk("model_fin",   64'(finished),    64'(m_fin));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic beat(input logic [63:0] ops, input logic [15:0] sc, input logic md,
                        input logic bnd, input logic stl);
        operand_i      = ops;
        scale_i        = sc;
        mode           = md;
        stage_boundary = bnd;
        stall_i        = stl;
        @(posedge CLK_i);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [63:0] e1, input logic [63:0] e2,
                           input int ep, input int es, input logic ef);
        chk({nm, "_op1"},   operand1_o,    e1);
        chk({nm, "_op2"},   operand2_o,    e2);
        chk({nm, "_pos"},   64'(pos),      64'(ep));
        chk({nm, "_stage"}, 64'(stage),    64'(es));
        chk({nm, "_fin"},   64'(finished), 64'(ef));
    endtask

    logic [63:0] va, vb, vc, vd;

    initial begin
        RST_i = 1'b0; stall_i = 1'b0; stage_boundary = 1'b0; mode = 1'b0;
        operand_i = 64'd0; scale_i = 16'd0;
        va = pk(1, 2, 3, 4); vb = pk(5, 6, 7, 8); vc = pk(9, 10, 11, 12); vd = pk(13, 14, 15, 16);

        for (int i = 0; i < 3; i++) begin
            beat({$urandom, $urandom}, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        chk_out("reset", 64'd0, 64'd0, 0, 0, 1'b0);
        chk_en = 1'b1;
        RST_i  = 1'b1;

        beat(pk(100, -100, 32767, -32768), 16'h0180, 1'b0, 1'b0, 1'b0);
        chk_out("scale15", pk(150, -150, 32767, -32768), pk(100, -100, 32767, -32768), 0, 0, 1'b0);
        beat(pk(3, -3, 1, -1), 16'h0080, 1'b0, 1'b0, 1'b0);
        chk_out("round05", pk(2, -1, 1, 0), pk(3, -3, 1, -1), 1, 0, 1'b0);
        beat(pk(7, 7, 7, 7), 16'h0100, 1'b0, 1'b1, 1'b0);
        chk_out("seg0_end", pk(7, 7, 7, 7), pk(7, 7, 7, 7), 2, 0, 1'b1);

        beat(va, 16'd2, 1'b1, 1'b0, 1'b0);
        chk_out("norm_b0", va, 64'd0, 0, 1, 1'b0);
        beat(vb, 16'd2, 1'b1, 1'b0, 1'b0);
        chk_out("norm_b1", vb, 64'd0, 1, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat(64'hffff_ffff_ffff_ffff, 16'd0, 1'b0, 1'b1, 1'b1);
            chk_out("stall", vb, 64'd0, 1, 1, 1'b0);
        end
        beat(vc, 16'd2, 1'b1, 1'b0, 1'b0);
        chk_out("norm_b2", 64'd0, vc, 2, 1, 1'b0);
        beat(vd, 16'd2, 1'b1, 1'b1, 1'b0);
        chk_out("norm_b3", 64'd0, vd, 3, 1, 1'b1);
        beat(va, 16'd2, 1'b1, 1'b0, 1'b0);
        chk_out("seg2_b0", va, 64'd0, 0, 2, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            beat(pk(i * 256, -i * 256, i, 0), 16'h0003, 1'(i % 2), 1'b0, 1'b0);
        end
        chk("pos5", 64'(pos), 64'd5);
        chk("pos5_op2", operand2_o, pk(5 * 256, -5 * 256, 5, 0));

        #2;
        RST_i = 1'b0;
        #1;
        chk_out("async_rst", 64'd0, 64'd0, 0, 0, 1'b0);
        @(posedge CLK_i);
        #1;
        RST_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            beat(pk(i, 0, 0, 0), 16'h0100, 1'b0, 1'b1, 1'b0);
            chk_out("single_seg", pk(i, 0, 0, 0), pk(i, 0, 0, 0), 0, i, 1'b1);
        end
        beat(64'd0, 16'h0100, 1'b0, 1'b0, 1'b1);
        chk_out("fin_hold", pk(15, 0, 0, 0), pk(15, 0, 0, 0), 0, 15, 1'b1);
        beat(pk(-1, -2, -3, -4), 16'h0100, 1'b0, 1'b0, 1'b0);
        chk_out("wrap", pk(-1, -2, -3, -4), pk(-1, -2, -3, -4), 0, 0, 1'b0);

        @(negedge CLK_i);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
